// File: rtl/branch_resolve_unit.sv
// Branch resolution: detects mispredicts, drives a one-shot fetch redirect plus a
// multi-cycle flush, and queues BTB update feedback with drop accounting.
module branch_resolve_unit #(
  parameter int PC_SIZE      = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               res_valid,
  input  logic [PC_SIZE-1:0] res_pc,
  input  logic               res_is_branch,
  input  logic               res_taken,
  input  logic [PC_SIZE-1:0] res_target,
  input  logic               pred_hit,
  input  logic               pred_taken,
  input  logic [PC_SIZE-1:0] pred_target,
  output logic               redirect_valid,
  output logic [PC_SIZE-1:0] redirect_pc,
  output logic               flush,
  output logic               fb_valid,
  input  logic               fb_ready,
  output logic [PC_SIZE-1:0] fb_pc,
  output logic               fb_branch,
  output logic [PC_SIZE-1:0] fb_target,
  output logic               fifo_full,
  output logic [7:0]         drop_count,
  output logic [15:0]        branch_count,
  output logic [15:0]        mispredict_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef struct packed {
    logic [PC_SIZE-1:0] pc;
    logic               branch;
    logic [PC_SIZE-1:0] target;
  } fb_entry_t;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t             state, state_nxt;
  logic [FW-1:0]      fl_cnt, fl_cnt_nxt;
  logic               accept, pred_tk, mispred, do_redirect;
  logic [PC_SIZE-1:0] fall_pc, correct_pc;

  assign accept      = res_valid & (state == IDLE);
  assign pred_tk     = pred_hit & pred_taken;
  assign fall_pc     = res_pc + PC_SIZE'(1);
  assign mispred     = res_is_branch
                     ? ((res_taken != pred_tk) | (res_taken & pred_tk & (pred_target != res_target)))
                     : pred_tk;
  assign correct_pc  = (res_is_branch & res_taken) ? res_target : fall_pc;
  assign do_redirect = accept & mispred;

  // fl_cnt counts remaining flush cycles after the current one
  always_comb begin
    state_nxt  = state;
    fl_cnt_nxt = fl_cnt;
    case (state)
      IDLE: if (do_redirect) begin
        state_nxt  = FLUSH;
        fl_cnt_nxt = FW'(FLUSH_CYCLES - 1);
      end
      FLUSH: begin
        if (fl_cnt == '0) state_nxt = IDLE;
        else              fl_cnt_nxt = fl_cnt - FW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state          <= IDLE;
      fl_cnt         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state          <= state_nxt;
      fl_cnt         <= fl_cnt_nxt;
      redirect_valid <= do_redirect;
      if (do_redirect) redirect_pc <= correct_pc;
    end
  end

  assign flush = (state == FLUSH);

  // feedback queue
  fb_entry_t       mem [FIFO_DEPTH];
  fb_entry_t       new_entry, head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            empty, push_req, push, pop, drop;

  assign empty     = (count == '0);
  assign fifo_full = (count == CW'(FIFO_DEPTH));
  assign push_req  = accept & (res_is_branch | pred_hit);
  assign pop       = ~empty & fb_ready;
  // when full, a same-cycle pop frees the head slot that wr_ptr points at
  assign push      = push_req & (~fifo_full | pop);
  assign drop      = push_req & fifo_full & ~pop;

  assign new_entry.pc     = res_pc;
  assign new_entry.branch = res_is_branch & res_taken;
  assign new_entry.target = res_is_branch ? res_target : fall_pc;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // storage is not reset, so data is masked until an entry is present
  assign head      = mem[rd_ptr];
  assign fb_valid  = ~empty;
  assign fb_pc     = fb_valid ? head.pc     : '0;
  assign fb_branch = fb_valid ? head.branch : 1'b0;
  assign fb_target = fb_valid ? head.target : '0;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      drop_count       <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      if (accept && res_is_branch && branch_count != 16'hFFFF)
        branch_count <= branch_count + 16'd1;
      if (do_redirect && mispredict_count != 16'hFFFF)
        mispredict_count <= mispredict_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit; redirect and feedback outputs are
// checked by a monitor against scoreboard queues filled at stimulus time.
module tb_branch_resolve_unit;
  logic        clk = 1'b0;
  logic        n_rst;
  logic        res_valid, res_is_branch, res_taken, pred_hit, pred_taken;
  logic [15:0] res_pc, res_target, pred_target;
  logic        redirect_valid, flush, fb_valid, fb_ready, fb_branch, fifo_full;
  logic [15:0] redirect_pc, fb_pc, fb_target, branch_count, mispredict_count;
  logic [7:0]  drop_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] rd_q[$];
  logic [32:0] fb_q[$];

  always #5 clk = ~clk;

  branch_resolve_unit #(.PC_SIZE(16), .FIFO_DEPTH(4), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .n_rst(n_rst),
    .res_valid(res_valid), .res_pc(res_pc), .res_is_branch(res_is_branch),
    .res_taken(res_taken), .res_target(res_target),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_pc(fb_pc), .fb_branch(fb_branch),
    .fb_target(fb_target), .fifo_full(fifo_full), .drop_count(drop_count),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: sample away from the active edge
  always @(negedge clk) begin
    if (redirect_valid === 1'b1) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_err++;
        $display("FAIL redirect_unexpected: got pc %0h expected no redirect", redirect_pc);
      end else begin
        logic [15:0] e;
        e = rd_q.pop_front();
        if (redirect_pc !== e) begin
          n_err++;
          $display("FAIL redirect_pc: got %0h expected %0h", redirect_pc, e);
        end
      end
    end
    if (fb_valid === 1'b1 && fb_ready === 1'b1) begin
      n_cmp++;
      if (fb_q.size() == 0) begin
        n_err++;
        $display("FAIL fb_unexpected: got %0h expected empty", {fb_pc, fb_branch, fb_target});
      end else begin
        logic [32:0] e;
        e = fb_q.pop_front();
        if ({fb_pc, fb_branch, fb_target} !== e) begin
          n_err++;
          $display("FAIL fb_entry: got %0h expected %0h", {fb_pc, fb_branch, fb_target}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] pc, input logic br, input logic tk,
                       input logic [15:0] tgt, input logic hit, input logic ptk,
                       input logic [15:0] ptgt, input logic exp_rd, input logic [15:0] exp_rpc,
                       input logic exp_fb, input logic exp_fbb, input logic [15:0] exp_fbt);
    res_pc = pc; res_is_branch = br; res_taken = tk; res_target = tgt;
    pred_hit = hit; pred_taken = ptk; pred_target = ptgt; res_valid = 1'b1;
    if (exp_rd) rd_q.push_back(exp_rpc);
    if (exp_fb) fb_q.push_back({pc, exp_fbb, exp_fbt});
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; res_valid = 1'b0; fb_ready = 1'b1;
    res_pc = '0; res_is_branch = 0; res_taken = 0; res_target = '0;
    pred_hit = 0; pred_taken = 0; pred_target = '0;
    cyc(2);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_fb_valid", fb_valid, 0);
    chk("rst_fifo_full", fifo_full, 0);
    chk("rst_fb_data", {fb_pc, fb_target}, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    n_rst = 1'b1;
    cyc(1);

    // correct taken branch
    issue(16'h0010, 1, 1, 16'h0040, 1, 1, 16'h0040, 0, 0, 1, 1, 16'h0040);
    chk("t1_flush", flush, 0);
    chk("t1_fb_valid", fb_valid, 1);
    chk("t1_branch_count", branch_count, 1);
    cyc(2);

    // not-taken mispredict, then a resolve during flush that must be ignored
    issue(16'h0020, 1, 0, 16'h0077, 1, 1, 16'h0050, 1, 16'h0021, 1, 0, 16'h0077);
    chk("t2_flush_c1", flush, 1);
    chk("t2_mispredict_count", mispredict_count, 1);
    issue(16'h0030, 1, 1, 16'h0099, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
    chk("t2_flush_c2", flush, 1);
    chk("t2_redirect_one_cycle", redirect_valid, 0);
    cyc(1);
    chk("t2_flush_end", flush, 0);
    chk("t2_branch_count", branch_count, 2);
    chk("t2_mispredict_hold", mispredict_count, 1);

    // non-branch aliasing a taken prediction at the top of the PC space
    issue(16'hFFFF, 0, 0, 16'h1234, 1, 1, 16'h0008, 1, 16'h0000, 1, 0, 16'h0000);
    chk("t3_mispredict_count", mispredict_count, 2);
    chk("t3_branch_count", branch_count, 2);
    cyc(3);

    // backpressure: fifth push is dropped, head held stable
    fb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue(16'h0100 + 16'(i), 1, 1, 16'h0200 + 16'(i), 1, 1, 16'h0200 + 16'(i),
            0, 0, (i < 4), 1, 16'h0200 + 16'(i));
      chk("t4_fb_pc_stable", fb_pc, 16'h0100);
      chk("t4_fb_target_stable", fb_target, 16'h0200);
      if (i == 3) chk("t4_full_after4", fifo_full, 1);
      if (i == 3) chk("t4_no_drop_yet", drop_count, 0);
    end
    chk("t4_drop_count", drop_count, 1);
    chk("t4_still_full", fifo_full, 1);
    fb_ready = 1'b1;
    cyc(5);
    chk("t4_drained", fb_valid, 0);
    chk("t4_not_full", fifo_full, 0);

    // full queue with simultaneous push and pop
    fb_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      issue(16'h0300 + 16'(i), 1, 1, 16'h0400 + 16'(i), 1, 1, 16'h0400 + 16'(i),
            0, 0, 1, 1, 16'h0400 + 16'(i));
    chk("t5_full", fifo_full, 1);
    fb_ready = 1'b1;
    issue(16'h0310, 1, 1, 16'h0410, 1, 1, 16'h0410, 0, 0, 1, 1, 16'h0410);
    fb_ready = 1'b0;
    chk("t5_full_kept", fifo_full, 1);
    chk("t5_drop_unchanged", drop_count, 1);
    chk("t5_new_head", fb_pc, 16'h0301);
    fb_ready = 1'b1;
    cyc(5);
    chk("t5_drained", fb_valid, 0);
    chk("t5_branch_count", branch_count, 12);
    chk("t5_mispredict_count", mispredict_count, 2);

    // reset during the second flush cycle discards queued feedback
    fb_ready = 1'b0;
    issue(16'h0040, 1, 1, 16'h0080, 0, 0, 16'h0000, 1, 16'h0080, 0, 0, 0);
    chk("t6_flush_c1", flush, 1);
    cyc(1);
    chk("t6_flush_c2", flush, 1);
    chk("t6_fb_pending", fb_valid, 1);
    n_rst = 1'b0;
    cyc(1);
    chk("t6_flush_off", flush, 0);
    chk("t6_fb_valid", fb_valid, 0);
    chk("t6_counters", {branch_count, mispredict_count}, 0);
    chk("t6_drop", drop_count, 0);
    chk("t6_full", fifo_full, 0);
    n_rst = 1'b1;
    fb_ready = 1'b1;
    cyc(2);

    chk("rd_q_empty", rd_q.size(), 0);
    chk("fb_q_empty", fb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter PC_SIZE, default 16, PC width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, feedback queue entries (power of two, >=2).
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, flush pulse length in cycles (>=1).
REQ-004 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have port n_rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port res_valid  in  1  resolved instruction present this cycle.
REQ-007 SHALL have port res_pc  in  PC_SIZE  PC of resolved instruction.
REQ-008 SHALL have port res_is_branch  in  1  instruction is a branch.
REQ-009 SHALL have port res_taken  in  1  actual branch outcome.
REQ-010 SHALL have port res_target  in  PC_SIZE  actual taken target.
REQ-011 SHALL have ports pred_hit, pred_taken (in 1 each) and pred_target (in PC_SIZE): prediction carried with the instruction.
REQ-012 SHALL have ports redirect_valid (out 1) and redirect_pc (out PC_SIZE): fetch redirect.
REQ-013 SHALL have port flush  out  1  squash younger pipeline stages.
REQ-014 SHALL have ports fb_valid (out 1), fb_ready (in 1), fb_pc (out PC_SIZE), fb_branch (out 1), fb_target (out PC_SIZE): feedback to branch target buffer.
REQ-015 SHALL have ports fifo_full (out 1) and drop_count (out 8): queue status.
REQ-016 SHALL have ports branch_count and mispredict_count (out 16 each): statistics.

Function
REQ-017 Accepted resolve = res_valid & FSM in IDLE; resolves in FLUSH SHALL be ignored entirely (wrong path).
REQ-018 Predicted-taken p = pred_hit & pred_taken; fall-through = res_pc + 1, modulo 2^PC_SIZE.
REQ-019 Mispredict (branch) SHALL be res_taken != p, or res_taken & p & (pred_target != res_target).
REQ-020 Mispredict (non-branch) SHALL be p = 1.
REQ-021 Correct PC SHALL be res_target if res_is_branch & res_taken, else fall-through.
REQ-022 On accepted mispredict: next cycle redirect_valid = 1 for exactly one cycle, redirect_pc = correct PC; FSM IDLE -> FLUSH.
REQ-023 flush SHALL be high exactly FLUSH_CYCLES consecutive cycles, starting the redirect cycle; FSM returns to IDLE after the last flush cycle.
REQ-024 Enqueue SHALL occur on accepted resolve with res_is_branch, or non-branch with pred_hit; entry = {res_pc, res_is_branch & res_taken, res_target (branch) / fall-through (non-branch)}.
REQ-025 Queue SHALL be FIFO: fb_* show head entry, fb_valid = non-empty; pop when fb_valid & fb_ready.
REQ-026 fb_* SHALL be held stable while fb_valid & ~fb_ready.
REQ-027 Push and pop same cycle SHALL both succeed, including when full (occupancy unchanged).
REQ-028 Push when full without pop SHALL drop the entry; drop_count +1, saturating at 255.
REQ-029 Push into empty queue SHALL make fb_valid = 1 the next cycle (one-cycle latency).
REQ-030 fifo_full = occupancy == FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
REQ-031 branch_count +1 per accepted branch resolve; mispredict_count +1 per accepted mispredict; both saturate at 0xFFFF.
REQ-032 Redirect/flush SHALL NOT depend on queue state.

Reset
REQ-033 n_rst = 0 at a clock edge SHALL set FSM IDLE, queue empty, all counters 0.
REQ-034 During/after reset: redirect_valid, flush, fb_valid, fifo_full = 0; redirect_pc, fb_* data = 0.
REQ-035 Reset asserted mid-flush SHALL terminate flush the following cycle; queued entries are discarded.

Verification
REQ-036 Correct taken: pc=0x0010, branch, taken, target=0x0040, pred hit/taken/0x0040 -> no redirect/flush; fb entry {0x0010,1,0x0040} one cycle later; branch_count=1.
REQ-037 Not-taken mispredict: pc=0x0020, branch, not taken, pred hit/taken -> redirect_valid 1 cycle, redirect_pc=0x0021, flush 2 cycles, mispredict_count=1; resolve during flush ignored (counts unchanged).
REQ-038 Non-branch alias: pc=0xFFFF, non-branch, pred hit/taken -> redirect_pc=0x0000 (wrap), fb entry {0xFFFF,0,0x0000}.
REQ-039 Backpressure: fb_ready=0, 5 correct branch resolves -> fifo_full after 4, drop_count=1, fb_* stable; fb_ready=1 -> 4 entries drain in order.
REQ-040 Full + simultaneous push/pop: queue full, fb_ready=1, one push -> occupancy stays 4, drop_count unchanged, new entry at tail.
REQ-041 Reset in second flush cycle -> flush=0, fb_valid=0, counters 0 the next cycle.
